// File: rtl/time_ctrl_pkg.sv
// Shared types and BCD limits for the time-set controller.
package time_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_COMMIT  = 2'd3
  } state_e;

  localparam logic [7:0] HR_MAX  = 8'h23;
  localparam logic [7:0] MIN_MAX = 8'h59;

endpackage

// File: rtl/bcd_mod_step.sv
// Two-digit BCD increment/decrement with wrap between 00 and MAX.
module bcd_mod_step #(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic [7:0] val,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] nxt
);

  // inc and dec together cancel out
  always_comb begin
    nxt = val;
    if (inc && !dec) begin
      if (val == MAX)               nxt = 8'h00;
      else if (val[3:0] == 4'd9)    nxt = {val[7:4] + 4'd1, 4'd0};
      else                          nxt = {val[7:4], val[3:0] + 4'd1};
    end else if (dec && !inc) begin
      if (val == 8'h00)             nxt = MAX;
      else if (val[3:0] == 4'd0)    nxt = {val[7:4] - 4'd1, 4'd9};
      else                          nxt = {val[7:4], val[3:0] - 4'd1};
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Set-mode sequencer between the button front-end and the HH:MM:SS counter.
// state      | meaning
// ST_RUN     | counter free-running, buttons except mode ignored
// ST_SET_HR  | counter frozen, inc/dec edit the hour
// ST_SET_MIN | counter frozen, inc/dec edit the minute
// ST_COMMIT  | one-cycle parallel load of hh:mm:00
module time_set_ctrl
  import time_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       dec_btn,
  input  logic [3:0] cur_m_hr,
  input  logic [3:0] cur_l_hr,
  input  logic [3:0] cur_m_min,
  input  logic [3:0] cur_l_min,
  output logic       cnt_en,
  output logic       load,
  output logic [3:0] ld_m_hr,
  output logic [3:0] ld_l_hr,
  output logic [3:0] ld_m_min,
  output logic [3:0] ld_l_min,
  output logic [3:0] ld_m_sec,
  output logic [3:0] ld_l_sec,
  output logic       edit_hr,
  output logic       edit_min
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [7:0]      hr_q, hr_d, min_q, min_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic            cnt_en_q, cnt_en_d, load_q, load_d;
  logic            edit_hr_q, edit_hr_d, edit_min_q, edit_min_d;
  logic [7:0]      ld_hr_q, ld_hr_d, ld_min_q, ld_min_d;

  logic            hr_inc, hr_dec, min_inc, min_dec;
  logic [7:0]      hr_step, min_step;

  // mode wins over inc/dec in the same cycle
  assign hr_inc  = (state_q == ST_SET_HR)  && !mode_btn && inc_btn;
  assign hr_dec  = (state_q == ST_SET_HR)  && !mode_btn && dec_btn;
  assign min_inc = (state_q == ST_SET_MIN) && !mode_btn && inc_btn;
  assign min_dec = (state_q == ST_SET_MIN) && !mode_btn && dec_btn;

  bcd_mod_step #(.MAX(HR_MAX)) u_hr_step (
    .val (hr_q),
    .inc (hr_inc),
    .dec (hr_dec),
    .nxt (hr_step)
  );

  bcd_mod_step #(.MAX(MIN_MAX)) u_min_step (
    .val (min_q),
    .inc (min_inc),
    .dec (min_dec),
    .nxt (min_step)
  );

  always_comb begin
    state_d = state_q;
    hr_d    = hr_q;
    min_d   = min_q;
    idle_d  = idle_q;
    case (state_q)
      ST_RUN: begin
        idle_d = '0;
        if (mode_btn) begin
          hr_d    = {cur_m_hr, cur_l_hr};
          min_d   = {cur_m_min, cur_l_min};
          state_d = ST_SET_HR;
        end
      end
      ST_SET_HR, ST_SET_MIN: begin
        if (mode_btn) begin
          idle_d  = '0;
          state_d = (state_q == ST_SET_HR) ? ST_SET_MIN : ST_COMMIT;
        end else if (inc_btn || dec_btn) begin
          idle_d = '0;
          hr_d   = hr_step;
          min_d  = min_step;
        end else if (idle_q == IDLE_LAST) begin
          idle_d  = '0;
          state_d = ST_RUN;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end
      default: begin
        idle_d  = '0;
        state_d = ST_RUN;
      end
    endcase

    // outputs are registered against the next state so they line up with it
    cnt_en_d   = (state_d == ST_RUN);
    load_d     = (state_d == ST_COMMIT);
    edit_hr_d  = (state_d == ST_SET_HR);
    edit_min_d = (state_d == ST_SET_MIN);
    ld_hr_d    = load_d ? hr_d  : ld_hr_q;
    ld_min_d   = load_d ? min_d : ld_min_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      hr_q       <= 8'h00;
      min_q      <= 8'h00;
      idle_q     <= '0;
      cnt_en_q   <= 1'b1;
      load_q     <= 1'b0;
      edit_hr_q  <= 1'b0;
      edit_min_q <= 1'b0;
      ld_hr_q    <= 8'h00;
      ld_min_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      hr_q       <= hr_d;
      min_q      <= min_d;
      idle_q     <= idle_d;
      cnt_en_q   <= cnt_en_d;
      load_q     <= load_d;
      edit_hr_q  <= edit_hr_d;
      edit_min_q <= edit_min_d;
      ld_hr_q    <= ld_hr_d;
      ld_min_q   <= ld_min_d;
    end
  end

  assign cnt_en   = cnt_en_q;
  assign load     = load_q;
  assign edit_hr  = edit_hr_q;
  assign edit_min = edit_min_q;
  assign ld_m_hr  = ld_hr_q[7:4];
  assign ld_l_hr  = ld_hr_q[3:0];
  assign ld_m_min = ld_min_q[7:4];
  assign ld_l_min = ld_min_q[3:0];
  // seconds always commit as 00
  assign ld_m_sec = 4'd0;
  assign ld_l_sec = 4'd0;

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Set-mode controller for the HH:MM:SS BCD time counter. It sequences the counter between free-running and an edit mode in which the user sets hours, then minutes, with pulse buttons. It then commits the edited time to the counter through a one-cycle parallel load, with seconds forced to 00. It sits between the debounced button front-end and the time counter, and drives the counter's enable and load inputs.

## Interface
- `TIMEOUT`, default 30: consecutive clk cycles with no button pulse in an edit state before the edit is abandoned.

Ports:
- `clk`  in  1  system clock; same clock as the time counter (1 Hz tick domain).
- `rst`  in  1  synchronous, active-low reset.
- `mode_btn`  in  1  single-cycle pulse from the debounced front-end.
- `inc_btn`  in  1  single-cycle pulse.
- `dec_btn`  in  1  single-cycle pulse.
- `cur_m_hr`, `cur_l_hr`, `cur_m_min`, `cur_l_min`  in  4 each  live BCD digits from the counter.
- `cnt_en`  out  1  counter advance enable.
- `load`  out  1  one-cycle parallel-load strobe to the counter.
- `ld_m_hr`, `ld_l_hr`, `ld_m_min`, `ld_l_min`, `ld_m_sec`, `ld_l_sec`  out  4 each  load value, BCD.
- `edit_hr`, `edit_min`  out  1 each  field currently being edited (for display blink).

## Operation
- States: RUN, SET_HR, SET_MIN, COMMIT.
- RUN: `cnt_en`=1, `load`=0.
  - `mode_btn` captures the `cur_*` hour and minute digits into edit registers, then goes to SET_HR.
  - `inc_btn`/`dec_btn` are ignored.
- SET_HR: `cnt_en`=0, `edit_hr`=1.
  - inc: hour +1 in BCD, 23 wraps to 00.
  - dec: hour −1, 00 wraps to 23.
  - `mode_btn` goes to SET_MIN.
- SET_MIN: `cnt_en`=0, `edit_min`=1.
  - inc: minute +1, 59 wraps to 00.
  - dec: minute −1, 00 wraps to 59.
  - `mode_btn` goes to COMMIT.
- COMMIT: `load`=1 for exactly one cycle.
  - `ld_*` = edit hour and minute, with `ld_m_sec`=`ld_l_sec`=0.
  - Next state is RUN unconditionally.
  - All buttons are ignored.
- Simultaneous events in an edit state:
  - `mode_btn` has priority; inc/dec in the same cycle are discarded.
  - inc and dec together, without mode: no change, but the timeout counter still restarts.
- Timeout:
  - The idle counter restarts on any button pulse in SET_HR/SET_MIN.
  - On reaching `TIMEOUT` it forces RUN with no load; the counter resumes from its frozen value.
- Arithmetic:
  - Edit registers are 8-bit BCD (tens, units).
  - Inc/dec always yields a legal BCD value; no intermediate illegal digit is ever visible.
- `ld_*` holds its last value outside COMMIT; it is only meaningful while `load`=1.

## Timing
- All outputs are registered.
- Reset values:
  - state RUN;
  - `cnt_en`=1;
  - `load`=0;
  - all `ld_*`=0;
  - `edit_hr`=`edit_min`=0;
  - edit registers 00:00;
  - idle counter 0.
- Reset held low: outputs held at reset values.
- Reset mid-edit: return to RUN, no load issued.
- `mode_btn` sampled in RUN at edge t:
  - The `cur_*` values sampled at edge t are captured.
  - At edge t the counter still sees `cnt_en`=1, so it may advance once; that advance is not captured.
  - `cnt_en`=0 from edge t onward.
- `mode_btn` sampled in SET_MIN at edge t:
  - `load`=1 during cycle t..t+1, so the counter loads at edge t+1.
  - RUN with `cnt_en`=1 after edge t+1.
  - `cnt_en` is never 1 while `load`=1.
- Inc/dec take effect on edit registers one cycle after sampling.
- Button-to-state latency is 1 cycle.
- Timeout: RUN is entered on the edge where the idle count reaches `TIMEOUT`.

## Structure
- Package `time_ctrl_pkg`:
  - state enum;
  - BCD limit constants HR_MAX=8'h23, MIN_MAX=8'h59.
- Sub-module `bcd_mod_step`:
  - combinational BCD inc/dec with a parameterised maximum and wrap;
  - instantiated twice, once for hours and once for minutes.
- Idle counter width is $clog2(TIMEOUT+1).

## Test plan
- Reset, counter at 12:34:56, `mode_btn`: `cnt_en`=0 next cycle; edit hour=12, minute=34; `edit_hr`=1.
- Hour at 23, one inc, then from 00 one dec: 00, then 23. Minute at 59, one inc: 00.
- Set 07:45 and press mode twice: single-cycle `load`=1 with `ld_*`=0,7,4,5,0,0; `cnt_en`=0 that cycle; `cnt_en`=1 the next.
- `mode_btn`+`inc_btn` in the same cycle in SET_HR: state goes to SET_MIN, hour unchanged. inc+dec together: value unchanged.
- Enter SET_HR with no pulses for `TIMEOUT` (30) cycles: RUN, `load` never asserted, `cnt_en`=1. One inc at cycle 29 restarts the count.
- Assert `rst` low during SET_MIN: next cycle RUN, `cnt_en`=1, `load`=0, `edit_min`=0.
